// File: rtl/match_filter_ctrl_pkg.sv
// Shared definitions for the match_filter coefficient/detection controller:
// register offsets, control bit positions, state encoding and small helpers.
package match_filter_ctrl_pkg;

   localparam int NUM_COEF = 7;

   localparam logic [6:0] REG_COEF0     = 7'd0;
   localparam logic [6:0] REG_COEF_LAST = 7'd6;
   localparam logic [6:0] REG_CTRL      = 7'd7;
   localparam logic [6:0] REG_DEAD      = 7'd8;

   localparam int CTRL_ENABLE_BIT = 0;
   localparam int CTRL_LOAD_BIT   = 1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_SETTLE = 3'd2,
      ST_ARMED  = 3'd3,
      ST_DEAD   = 3'd4
   } mf_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == 16'hFFFF) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/mf_coef_regs.sv
// Serial register decode for the match filter controller: coefficient
// staging file, enable level, self-clearing load strobe and dead time.
module mf_coef_regs
   import match_filter_ctrl_pkg::*;
#(
   parameter logic [6:0] BASE_ADDR = 7'd80
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      serial_strobe,
   input  logic [6:0]                serial_addr,
   input  logic [31:0]               serial_data,
   input  logic                      busy,
   output logic [NUM_COEF-1:0][31:0] stage,
   output logic                      enable,
   output logic                      load_wr,
   output logic [15:0]               deadtime
);

   logic [NUM_COEF-1:0][31:0] stage_d, stage_q;
   logic                      enable_d, enable_q;
   logic [15:0]               deadtime_d, deadtime_q;
   logic [6:0]                offset;
   logic                      hit;

   // Work out which register of this block, if any, the bus is addressing.
   always_comb begin
      offset = serial_addr - BASE_ADDR;
      hit    = serial_strobe && (serial_addr >= BASE_ADDR) && (offset <= REG_DEAD);
   end

   // Next register values; staging words are frozen while a burst is streaming
   // and load is a one-cycle strobe that never holds.
   always_comb begin
      stage_d    = stage_q;
      enable_d   = enable_q;
      deadtime_d = deadtime_q;
      load_wr    = 1'b0;
      if (hit) begin
         if (offset <= REG_COEF_LAST) begin
            if (!busy) begin
               stage_d[offset[2:0]] = serial_data;
            end
         end else if (offset == REG_CTRL) begin
            enable_d = serial_data[CTRL_ENABLE_BIT];
            load_wr  = serial_data[CTRL_LOAD_BIT];
         end else begin
            deadtime_d = serial_data[15:0];
         end
      end
   end

   // Register file state with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stage_q    <= '0;
         enable_q   <= 1'b0;
         deadtime_q <= 16'd0;
      end else begin
         stage_q    <= stage_d;
         enable_q   <= enable_d;
         deadtime_q <= deadtime_d;
      end
   end

   assign stage    = stage_q;
   assign enable   = enable_q;
   assign deadtime = deadtime_q;

endmodule

// File: rtl/match_filter_ctrl.sv
// Match filter controller: streams staged coefficients into the filter,
// waits for the filter to settle, then turns qualified matches into
// timestamped, dead-time-limited events.
module match_filter_ctrl
   import match_filter_ctrl_pkg::*;
#(
   parameter logic [6:0] BASE_ADDR      = 7'd80,
   parameter int         SETTLE_STROBES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        serial_strobe,
   input  logic [6:0]  serial_addr,
   input  logic [31:0] serial_data,
   input  logic        rxstrobe,
   input  logic        valid,
   input  logic        match,
   input  logic [31:0] timestamp,
   output logic [31:0] cdata,
   output logic [2:0]  cstate,
   output logic        cwrite,
   output logic        busy,
   output logic        armed,
   output logic        match_event,
   output logic [31:0] match_time,
   output logic [15:0] match_count
);

   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_STROBES - 1);
   localparam logic [2:0]  LAST_IDX    = 3'(NUM_COEF);

   logic [NUM_COEF-1:0][31:0] stage;
   logic                      enable;
   logic                      load_wr;
   logic [15:0]               deadtime;

   mf_state_t   state_d, state_q;
   logic [2:0]  idx_d, idx_q;
   logic [15:0] settle_d, settle_q;
   logic [15:0] dead_d, dead_q;
   logic        loaded_d, loaded_q;
   logic [31:0] cdata_d, cdata_q;
   logic [2:0]  cstate_d, cstate_q;
   logic        cwrite_d, cwrite_q;
   logic        busy_d, busy_q;
   logic        armed_d, armed_q;
   logic        match_event_d, match_event_q;
   logic [31:0] match_time_d, match_time_q;
   logic [15:0] match_count_d, match_count_q;
   logic        match_hit;

   mf_coef_regs #(
      .BASE_ADDR(BASE_ADDR)
   ) u_coef_regs (
      .clk          (clk),
      .reset        (reset),
      .serial_strobe(serial_strobe),
      .serial_addr  (serial_addr),
      .serial_data  (serial_data),
      .busy         (busy_q),
      .stage        (stage),
      .enable       (enable),
      .load_wr      (load_wr),
      .deadtime     (deadtime)
   );

   // Next-state and next-output logic; a load write beats every other
   // condition, and a cleared enable drops any active detection state.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      settle_d      = settle_q;
      dead_d        = dead_q;
      loaded_d      = loaded_q;
      cdata_d       = '0;
      cstate_d      = 3'd0;
      cwrite_d      = 1'b0;
      match_event_d = 1'b0;
      match_time_d  = match_time_q;
      match_count_d = match_count_q;
      match_hit     = rxstrobe && valid && match;

      if (load_wr) begin
         state_d  = ST_LOAD;
         idx_d    = 3'd1;
         cdata_d  = stage[0];
         cstate_d = 3'd1;
         cwrite_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (enable && loaded_q) begin
                  state_d  = ST_SETTLE;
                  settle_d = 16'd0;
               end
            end
            ST_LOAD: begin
               if (idx_q != LAST_IDX) begin
                  cdata_d  = stage[idx_q];
                  cstate_d = idx_q + 3'd1;
                  cwrite_d = 1'b1;
                  idx_d    = idx_q + 3'd1;
               end else begin
                  loaded_d      = 1'b1;
                  match_count_d = 16'd0;
                  settle_d      = 16'd0;
                  state_d       = enable ? ST_SETTLE : ST_IDLE;
               end
            end
            ST_SETTLE: begin
               if (!enable) begin
                  state_d = ST_IDLE;
               end else if (rxstrobe) begin
                  if (settle_q == SETTLE_LAST) begin
                     state_d = ST_ARMED;
                  end else begin
                     settle_d = settle_q + 16'd1;
                  end
               end
            end
            ST_ARMED: begin
               if (!enable) begin
                  state_d = ST_IDLE;
               end else if (match_hit) begin
                  match_event_d = 1'b1;
                  match_time_d  = timestamp;
                  match_count_d = sat_inc16(match_count_q);
                  if (deadtime != 16'd0) begin
                     state_d = ST_DEAD;
                     dead_d  = deadtime;
                  end
               end
            end
            ST_DEAD: begin
               if (!enable) begin
                  state_d = ST_IDLE;
               end else if (rxstrobe) begin
                  dead_d = dead_q - 16'd1;
                  if (dead_q == 16'd1) begin
                     state_d = ST_ARMED;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d  = (state_d == ST_LOAD);
      armed_d = (state_d == ST_ARMED);
   end

   // Controller state and registered outputs, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         idx_q         <= 3'd0;
         settle_q      <= 16'd0;
         dead_q        <= 16'd0;
         loaded_q      <= 1'b0;
         cdata_q       <= 32'd0;
         cstate_q      <= 3'd0;
         cwrite_q      <= 1'b0;
         busy_q        <= 1'b0;
         armed_q       <= 1'b0;
         match_event_q <= 1'b0;
         match_time_q  <= 32'd0;
         match_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         settle_q      <= settle_d;
         dead_q        <= dead_d;
         loaded_q      <= loaded_d;
         cdata_q       <= cdata_d;
         cstate_q      <= cstate_d;
         cwrite_q      <= cwrite_d;
         busy_q        <= busy_d;
         armed_q       <= armed_d;
         match_event_q <= match_event_d;
         match_time_q  <= match_time_d;
         match_count_q <= match_count_d;
      end
   end

   assign cdata       = cdata_q;
   assign cstate      = cstate_q;
   assign cwrite      = cwrite_q;
   assign busy        = busy_q;
   assign armed       = armed_q;
   assign match_event = match_event_q;
   assign match_time  = match_time_q;
   assign match_count = match_count_q;

endmodule

// File: tb/tb_match_filter_ctrl.sv
// Self-checking bench for match_filter_ctrl: table-driven load burst and
// event vectors, hand-written corner sequences, and randomized strobes
// checked against a strobe-index model of the dead-time rule.
module tb_match_filter_ctrl;

   localparam logic [6:0] BASE = 7'd80;

   logic        clk = 1'b0;
   logic        reset;
   logic        serial_strobe;
   logic [6:0]  serial_addr;
   logic [31:0] serial_data;
   logic        rxstrobe;
   logic        valid;
   logic        match;
   logic [31:0] timestamp;
   logic [31:0] cdata;
   logic [2:0]  cstate;
   logic        cwrite;
   logic        busy;
   logic        armed;
   logic        match_event;
   logic [31:0] match_time;
   logic [15:0] match_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        cwrite;
      logic [2:0]  cstate;
      logic [31:0] cdata;
      logic        busy;
   } burst_vec_t;

   typedef struct {
      logic        s;
      logic        v;
      logic        m;
      logic [31:0] ts;
      logic        expEvent;
      logic [15:0] expCount;
      logic [31:0] expTime;
   } ev_vec_t;

   burst_vec_t  burstTab[8];
   ev_vec_t     evTab[8];
   logic [31:0] stageVal[7];

   match_filter_ctrl #(
      .BASE_ADDR     (BASE),
      .SETTLE_STROBES(16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .serial_strobe(serial_strobe),
      .serial_addr  (serial_addr),
      .serial_data  (serial_data),
      .rxstrobe     (rxstrobe),
      .valid        (valid),
      .match        (match),
      .timestamp    (timestamp),
      .cdata        (cdata),
      .cstate       (cstate),
      .cwrite       (cwrite),
      .busy         (busy),
      .armed        (armed),
      .match_event  (match_event),
      .match_time   (match_time),
      .match_count  (match_count)
   );

   // Free-running receive clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic regWrite(input logic [6:0] off, input logic [31:0] data);
      serial_strobe = 1'b1;
      serial_addr   = BASE + off;
      serial_data   = data;
      tick();
      serial_strobe = 1'b0;
   endtask

   task automatic applyStimulus(input logic s, input logic v, input logic m, input logic [31:0] ts);
      rxstrobe  = s;
      valid     = v;
      match     = m;
      timestamp = ts;
      tick();
      rxstrobe = 1'b0;
      valid    = 1'b0;
      match    = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_cdata"}, cdata, 32'd0);
      checkOutput({tag, "_cstate"}, 32'(cstate), 32'd0);
      checkOutput({tag, "_cwrite"}, 32'(cwrite), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_armed"}, 32'(armed), 32'd0);
      checkOutput({tag, "_event"}, 32'(match_event), 32'd0);
      checkOutput({tag, "_time"}, match_time, 32'd0);
      checkOutput({tag, "_count"}, 32'(match_count), 32'd0);
   endtask

   task automatic settleAndArm(input logic noisy);
      for (int s = 1; s <= 16; s++) begin
         applyStimulus(1'b1, noisy, noisy, 32'hA000 + 32'(s));
         checkOutput("settle_no_event", 32'(match_event), 32'd0);
         if (s == 15) checkOutput("armed_before_16", 32'(armed), 32'd0);
         if (s == 16) checkOutput("armed_after_16", 32'(armed), 32'd1);
      end
   endtask

   task automatic loadAndArm();
      regWrite(7'd7, 32'd3);
      repeat (7) tick();
      settleAndArm(1'b1);
      checkOutput("count_after_load", 32'(match_count), 32'd0);
   endtask

   initial begin
      int          nWrites;
      int          nBusy;
      logic        restarted;
      logic        pending;
      int          strobeIdx;
      int          lastStrobe;
      int          lastDead;
      logic        haveEvent;
      logic        expEv;
      logic [15:0] expCount;
      logic [31:0] expTime;
      logic        s, v, m;
      logic [31:0] ts;
      int          dt;

      reset         = 1'b0;
      serial_strobe = 1'b0;
      serial_addr   = 7'd0;
      serial_data   = 32'd0;
      rxstrobe      = 1'b0;
      valid         = 1'b0;
      match         = 1'b0;
      timestamp     = 32'd0;

      for (int k = 0; k < 7; k++) begin
         stageVal[k] = ((32'(k) + 32'd1) << 16) | (32'(k) + 32'd2);
      end
      for (int i = 0; i < 7; i++) begin
         burstTab[i] = '{1'b1, 3'(i + 1), stageVal[i], 1'b1};
      end
      burstTab[7] = '{1'b0, 3'd0, 32'd0, 1'b0};

      evTab[0] = '{1'b1, 1'b1, 1'b1, 32'd100, 1'b1, 16'd1, 32'd100};
      evTab[1] = '{1'b0, 1'b0, 1'b0, 32'd101, 1'b0, 16'd1, 32'd100};
      evTab[2] = '{1'b1, 1'b1, 1'b1, 32'd102, 1'b1, 16'd2, 32'd102};
      evTab[3] = '{1'b0, 1'b0, 1'b0, 32'd103, 1'b0, 16'd2, 32'd102};
      evTab[4] = '{1'b1, 1'b1, 1'b1, 32'd104, 1'b1, 16'd3, 32'd104};
      evTab[5] = '{1'b0, 1'b1, 1'b1, 32'd105, 1'b0, 16'd3, 32'd104};
      evTab[6] = '{1'b1, 1'b0, 1'b1, 32'd106, 1'b0, 16'd3, 32'd104};
      evTab[7] = '{1'b1, 1'b1, 1'b0, 32'd107, 1'b0, 16'd3, 32'd104};

      $display("[TB] reset state");
      repeat (3) tick();
      checkAllZero("reset");
      reset = 1'b1;
      tick();

      $display("[TB] first load burst");
      for (int k = 0; k < 7; k++) regWrite(7'(k), stageVal[k]);
      regWrite(7'd7, 32'd3);
      for (int i = 0; i < 8; i++) begin
         checkOutput("burst_cwrite", 32'(cwrite), 32'(burstTab[i].cwrite));
         checkOutput("burst_cstate", 32'(cstate), 32'(burstTab[i].cstate));
         checkOutput("burst_cdata", cdata, burstTab[i].cdata);
         checkOutput("burst_busy", 32'(busy), 32'(burstTab[i].busy));
         if (i < 7) tick();
      end
      settleAndArm(1'b0);
      checkOutput("count_start", 32'(match_count), 32'd0);

      $display("[TB] event vectors, deadtime 0");
      for (int i = 0; i < 8; i++) begin
         applyStimulus(evTab[i].s, evTab[i].v, evTab[i].m, evTab[i].ts);
         checkOutput("ev_event", 32'(match_event), 32'(evTab[i].expEvent));
         checkOutput("ev_count", 32'(match_count), 32'(evTab[i].expCount));
         checkOutput("ev_time", match_time, evTab[i].expTime);
      end

      $display("[TB] deadtime 4, match on every strobe");
      regWrite(7'd8, 32'd4);
      loadAndArm();
      for (int i = 1; i <= 12; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 32'hB000 + 32'(i));
         checkOutput("dead4_event", 32'(match_event), 32'((i == 1) || (i == 6) || (i == 11)));
      end
      checkOutput("dead4_count", 32'(match_count), 32'd3);
      checkOutput("dead4_time", match_time, 32'hB00B);

      $display("[TB] load restart and busy staging write");
      regWrite(7'd7, 32'd3);
      nWrites   = 0;
      nBusy     = 0;
      restarted = 1'b0;
      pending   = 1'b0;
      for (int it = 0; it < 14; it++) begin
         if (cwrite) nWrites++;
         if (busy) nBusy++;
         if (pending) begin
            checkOutput("restart_cstate", 32'(cstate), 32'd1);
            checkOutput("restart_cdata", cdata, stageVal[0]);
            pending = 1'b0;
         end
         if (restarted && cwrite && (cstate == 3'd3)) begin
            checkOutput("busy_write_ignored", cdata, stageVal[2]);
         end
         if (it == 0) begin
            serial_strobe = 1'b1;
            serial_addr   = BASE + 7'd2;
            serial_data   = 32'hDEADBEEF;
         end else if (!restarted && (cstate == 3'd3)) begin
            serial_strobe = 1'b1;
            serial_addr   = BASE + 7'd7;
            serial_data   = 32'd3;
            restarted     = 1'b1;
            pending       = 1'b1;
         end
         tick();
         serial_strobe = 1'b0;
      end
      checkOutput("restart_seen", 32'(restarted), 32'd1);
      checkOutput("restart_cwrite_total", 32'(nWrites), 32'd10);
      checkOutput("restart_busy_total", 32'(nBusy), 32'd10);
      checkOutput("restart_count_cleared", 32'(match_count), 32'd0);
      settleAndArm(1'b0);

      $display("[TB] disable and re-enable");
      regWrite(7'd7, 32'd0);
      tick();
      checkOutput("disabled_armed", 32'(armed), 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hC000);
      checkOutput("disabled_no_event", 32'(match_event), 32'd0);
      regWrite(7'd7, 32'd1);
      tick();
      settleAndArm(1'b0);
      checkOutput("reenable_count", 32'(match_count), 32'd0);

      $display("[TB] randomized strobes against model");
      for (int round = 0; round < 3; round++) begin
         dt = int'($urandom_range(0, 5));
         regWrite(7'd8, 32'(dt));
         loadAndArm();
         strobeIdx  = 0;
         lastStrobe = 0;
         lastDead   = 0;
         haveEvent  = 1'b0;
         expCount   = 16'd0;
         expTime    = match_time;
         for (int c = 0; c < 500; c++) begin
            s  = 1'($urandom_range(0, 1));
            v  = ($urandom_range(0, 3) != 0);
            m  = ($urandom_range(0, 3) != 0);
            ts = $urandom;
            expEv = 1'b0;
            if (s) begin
               strobeIdx++;
               if (v && m && (!haveEvent || (strobeIdx - lastStrobe > lastDead))) begin
                  expEv      = 1'b1;
                  haveEvent  = 1'b1;
                  lastStrobe = strobeIdx;
                  lastDead   = dt;
                  expTime    = ts;
                  if (expCount != 16'hFFFF) expCount = expCount + 16'd1;
               end
            end
            applyStimulus(s, v, m, ts);
            checkOutput("rand_event", 32'(match_event), 32'(expEv));
            checkOutput("rand_count", 32'(match_count), 32'(expCount));
            checkOutput("rand_time", match_time, expTime);
         end
      end

      $display("[TB] match_count saturation");
      regWrite(7'd8, 32'd0);
      loadAndArm();
      for (int i = 1; i <= 65536; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 32'(i));
         if (i == 65535) checkOutput("sat_reach", 32'(match_count), 32'hFFFF);
      end
      checkOutput("sat_hold", 32'(match_count), 32'hFFFF);
      checkOutput("sat_event", 32'(match_event), 32'd1);
      checkOutput("sat_time", match_time, 32'd65536);

      $display("[TB] reset during load");
      regWrite(7'd7, 32'd3);
      tick();
      reset = 1'b0;
      tick();
      checkAllZero("midload");
      tick();
      checkOutput("midload_hold_cwrite", 32'(cwrite), 32'd0);
      reset = 1'b1;
      tick();
      tick();
      checkOutput("after_reset_cwrite", 32'(cwrite), 32'd0);
      checkOutput("after_reset_busy", 32'(busy), 32'd0);
      checkOutput("after_reset_cstate", 32'(cstate), 32'd0);

      $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
